// File: rtl/tick_timer_bank.sv
// Multi-channel tick timer: one shared prescaler feeds CH reload counters with periodic/one-shot expiry.
// Optional build macro TICK_TIMER_SHADOW_EN compares against per-channel shadow reloads latched at period boundaries.
module tick_timer_bank #(
   parameter int PRESCALE = 50000,
   parameter int CH       = 4,
   parameter int CW       = 10
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [CH-1:0]    Enable,
   input  logic [CH-1:0]    Clear,
   input  logic [CH-1:0]    OneShot,
   input  logic [CH*CW-1:0] CfgValue,
   output logic [CH-1:0]    Tick,
   output logic [CH-1:0]    Done
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0] p_q;
   logic          any_en;
   logic          base;

   assign any_en = |Enable;
   assign base   = any_en && (p_q == PW'(PRESCALE - 1));

   // The prescaler only idles when every channel is paused, so paused channels rejoin in phase.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         p_q <= '0;
      end else if (!any_en || base) begin
         p_q <= '0;
      end else begin
         p_q <= p_q + PW'(1);
      end
   end

`ifdef TICK_TIMER_SHADOW_EN
   logic load_q;

   // High for the first edge after reset release, when shadows pick up the live reloads.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         load_q <= 1'b1;
      end else begin
         load_q <= 1'b0;
      end
   end
`endif

   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic [CW-1:0] cfg;
      logic [CW-1:0] lim;
      logic [CW-1:0] cnt_q;
      logic          tick_q;
      logic          done_q;
      logic          run;
      logic          expire;

      assign cfg    = CfgValue[i*CW +: CW];
      assign run    = !Clear[i] && Enable[i] && !done_q && base;
      assign expire = run && (cnt_q >= lim);

`ifdef TICK_TIMER_SHADOW_EN
      logic [CW-1:0] shd_q;

      always_ff @(posedge Clk or posedge Rst) begin
         if (Rst) begin
            shd_q <= '0;
         end else if (load_q || Clear[i] || expire) begin
            shd_q <= cfg;
         end
      end

      assign lim = shd_q;
`else
      assign lim = cfg;
`endif

      // A count above the reload (after lowering it) expires on the next strobe instead of wrapping.
      always_ff @(posedge Clk or posedge Rst) begin
         if (Rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            done_q <= 1'b0;
         end else begin
            tick_q <= 1'b0;
            if (Clear[i]) begin
               cnt_q  <= '0;
               done_q <= 1'b0;
            end else if (expire) begin
               cnt_q  <= '0;
               tick_q <= 1'b1;
               done_q <= OneShot[i];
            end else if (run) begin
               cnt_q  <= cnt_q + CW'(1);
            end
         end
      end

      assign Tick[i] = tick_q;
      assign Done[i] = done_q;
   end

endmodule

// File: tb/tb_tick_timer_bank.sv
// Self-checking bench for tick_timer_bank: directed scenarios plus randomized traffic against a behavioural model.
module tb_tick_timer_bank;

   localparam int PRESCALE = 4;
   localparam int CH       = 4;
   localparam int CW       = 10;

   logic             Clk;
   logic             Rst;
   logic [CH-1:0]    Enable;
   logic [CH-1:0]    Clear;
   logic [CH-1:0]    OneShot;
   logic [CH*CW-1:0] CfgValue;
   logic [CH-1:0]    Tick;
   logic [CH-1:0]    Done;

   tick_timer_bank #(.PRESCALE(PRESCALE), .CH(CH), .CW(CW)) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .Enable   (Enable),
      .Clear    (Clear),
      .OneShot  (OneShot),
      .CfgValue (CfgValue),
      .Tick     (Tick),
      .Done     (Done)
   );

   // clock / reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // behavioural model: enabled-cycle phase and per-channel elapsed base ticks
   int            m_phase;
   int            m_cnt  [CH];
   int            m_shd  [CH];
   bit            m_done [CH];
   bit            m_tick [CH];
   bit            m_first;
   logic [2*CH-1:0] exp_q[$];

   task automatic model_reset();
      m_phase = 0;
      m_first = 1'b1;
      for (int i = 0; i < CH; i++) begin
         m_cnt[i]  = 0;
         m_shd[i]  = 0;
         m_done[i] = 1'b0;
         m_tick[i] = 1'b0;
      end
      exp_q.delete();
   endtask

   task automatic model_edge();
      bit              strobe;
      int              live;
      int              lim;
      logic [2*CH-1:0] e;
      strobe  = (Enable != '0) && (m_phase == PRESCALE - 1);
      m_phase = (Enable != '0) ? (m_phase + 1) % PRESCALE : 0;
      for (int i = 0; i < CH; i++) begin
         live = int'(CfgValue[i*CW +: CW]);
`ifdef TICK_TIMER_SHADOW_EN
         lim = m_shd[i];
`else
         lim = live;
`endif
         m_tick[i] = 1'b0;
         if (Clear[i]) begin
            m_cnt[i]  = 0;
            m_done[i] = 1'b0;
            m_shd[i]  = live;
         end else if (Enable[i] && !m_done[i] && strobe) begin
            if (m_cnt[i] < lim) begin
               m_cnt[i]++;
            end else begin
               m_cnt[i]  = 0;
               m_tick[i] = 1'b1;
               m_done[i] = OneShot[i];
               m_shd[i]  = live;
            end
         end
         if (m_first) m_shd[i] = live;
         e[i]      = m_tick[i];
         e[CH + i] = m_done[i];
      end
      m_first = 1'b0;
      exp_q.push_back(e);
   endtask

   // driver: called #1 after an edge; drives inputs, waits one edge, scores outputs
   task automatic cycle(input logic [CH-1:0] en, input logic [CH-1:0] clr,
                        input logic [CH-1:0] os, input logic [CH*CW-1:0] cfg);
      logic [2*CH-1:0] e;
      Enable   = en;
      Clear    = clr;
      OneShot  = os;
      CfgValue = cfg;
      @(posedge Clk);
      model_edge();
      #1;
      e = exp_q.pop_front();
      check("model_tick", 32'(Tick), 32'(e[CH-1:0]));
      check("model_done", 32'(Done), 32'(e[2*CH-1:CH]));
   endtask

   task automatic release_reset();
      #2;
      Rst = 1'b0;
      model_reset();
   endtask

   function automatic logic [CH*CW-1:0] cfg_of(input int c0, input int c1, input int c2, input int c3);
      logic [CH*CW-1:0] v;
      v = {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
      return v;
   endfunction

   logic [CH*CW-1:0] rcfg;
   logic [CH-1:0]    ren, rclr, ros;
   int               guard;

   initial begin
      Rst      = 1'b1;
      Enable   = '0;
      Clear    = '0;
      OneShot  = '0;
      CfgValue = '0;
      model_reset();
      repeat (3) @(posedge Clk);
      #1;
      check("rst_tick", 32'(Tick), 32'h0);
      check("rst_done", 32'(Done), 32'h0);
      release_reset();

      // periodic channel 0, Cfg=2: ticks after edges 12, 24, 36
      for (int e = 1; e <= 40; e++) begin
         cycle(4'b0001, 4'b0000, 4'b0000, cfg_of(2, 0, 0, 0));
         check("per_tick0", 32'(Tick[0]), 32'((e % 12) == 0));
         check("per_done0", 32'(Done[0]), 32'h0);
      end

      // one-shot channel 1, Cfg=1: single tick after edge 8, then frozen
      Rst = 1'b1;
      release_reset();
      for (int e = 1; e <= 24; e++) begin
         cycle(4'b0010, 4'b0000, 4'b0010, cfg_of(0, 1, 0, 0));
         check("os_tick1", 32'(Tick[1]), 32'(e == 8));
         check("os_done1", 32'(Done[1]), 32'(e >= 8));
      end
      cycle(4'b0010, 4'b0010, 4'b0010, cfg_of(0, 1, 0, 0));
      check("os_clr_done1", 32'(Done[1]), 32'h0);
      repeat (16) cycle(4'b0010, 4'b0000, 4'b0010, cfg_of(0, 1, 0, 0));

      // channel 2 Cfg=5 lowered to 1 when its count reaches 3
      Rst = 1'b1;
      release_reset();
      guard = 0;
      while (m_cnt[2] != 3 && guard < 100) begin
         cycle(4'b0100, 4'b0000, 4'b0000, cfg_of(0, 0, 5, 0));
         guard++;
      end
      check("lower_reach3", 32'(guard < 100), 32'h1);
      repeat (48) cycle(4'b0100, 4'b0000, 4'b0000, cfg_of(0, 0, 1, 0));

      // clear on the expiry edge, then a 2-base-tick pause of channel 0 while channel 3 runs
      Rst = 1'b1;
      release_reset();
      repeat (11) cycle(4'b0001, 4'b0000, 4'b0000, cfg_of(2, 0, 0, 0));
      cycle(4'b0001, 4'b0001, 4'b0000, cfg_of(2, 0, 0, 0));
      check("clr_exp_tick0", 32'(Tick[0]), 32'h0);
      repeat (6) cycle(4'b1001, 4'b0000, 4'b0000, cfg_of(2, 0, 0, 7));
      repeat (8) cycle(4'b1000, 4'b0000, 4'b0000, cfg_of(2, 0, 0, 7));
      repeat (20) cycle(4'b1001, 4'b0000, 4'b0000, cfg_of(2, 0, 0, 7));

      // all channels Cfg=0: all ticks together every 4 edges
      Rst = 1'b1;
      release_reset();
      for (int e = 1; e <= 16; e++) begin
         cycle(4'b1111, 4'b0000, 4'b0000, cfg_of(0, 0, 0, 0));
         check("all_tick", 32'(Tick), ((e % 4) == 0) ? 32'hF : 32'h0);
      end

      // asynchronous reset while Tick is high
      #2;
      Rst = 1'b1;
      #1;
      check("async_tick", 32'(Tick), 32'h0);
      check("async_done", 32'(Done), 32'h0);
      release_reset();
      for (int e = 1; e <= 12; e++) begin
         cycle(4'b0001, 4'b0000, 4'b0000, cfg_of(2, 0, 0, 0));
         check("post_rst_tick0", 32'(Tick[0]), 32'(e == 12));
      end

      // randomized traffic
      rcfg = cfg_of(1, 2, 0, 3);
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < CH; i++) begin
            ren[i]  = ($urandom_range(0, 99) < 85);
            rclr[i] = ($urandom_range(0, 99) < 2);
            ros[i]  = ($urandom_range(0, 99) < 25);
            if ($urandom_range(0, 99) < 3) rcfg[i*CW +: CW] = CW'($urandom_range(0, 5));
         end
         if ($urandom_range(0, 99) < 3) ren = '0;
         if ($urandom_range(0, 999) == 0) begin
            Rst = 1'b1;
            #1;
            check("rand_rst_tick", 32'(Tick), 32'h0);
            release_reset();
         end
         cycle(ren, rclr, ros, rcfg);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
